// File: rtl/bus_mem_resp_if.sv
// Request/response bundle between a BIU initiator and the memory-side responder.
// The initiator drives the cs/sel request and its operands. The responder returns
// read data, the fetched instruction and the ready/busy status.
interface bus_mem_resp_if;
    logic        cs;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [31:0] ir_out;
    logic        ready;
    logic        busy;

    modport master (
        output cs, sel, addr, wdata,
        input  rdata, ir_out, ready, busy
    );

    modport slave (
        input  cs, sel, addr, wdata,
        output rdata, ir_out, ready, busy
    );
endinterface

// File: rtl/bus_mem_resp.sv
// Memory-side bus responder for the 16-bit BIU transfer protocol.
// A request is accepted in IDLE and its operands are latched. The responder then
// waits WAIT_STATES cycles, performs a read, a write or a two-word instruction
// fetch against the internal word memory, and holds ready in DONE until the
// initiator drops cs (four-phase handshake).
module bus_mem_resp #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           reset,
    bus_mem_resp_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_FETCH2,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_READ  = 2'b01;
    localparam logic [1:0] SEL_WRITE = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;

    localparam int DEPTH = 1 << ADDR_W;

    // Value the wait counter holds on the last WAIT cycle. When WAIT_STATES is
    // zero the WAIT state is never entered, so the value is irrelevant there.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic [3:0]          wait_cnt_next;
    logic                accept;

    logic [1:0]          op_sel;
    logic [ADDR_W-1:0]   op_addr;
    logic [ADDR_W-1:0]   op_addr_inc;
    logic [15:0]         op_wdata;

    logic [15:0]         mem [DEPTH];
    logic [15:0]         rdata_q;
    logic [31:0]         ir_q;
    logic                ready_q;
    logic                busy_q;

    // The second fetch word wraps at the top of memory.
    assign op_addr_inc = op_addr + ADDR_W'(1);

    // Next-state logic and wait-counter sequencing.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cs && (bus.sel != SEL_NONE)) begin
                    accept     = 1'b1;
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next    = ST_ACCESS;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ST_ACCESS: begin
                state_next = (op_sel == SEL_FETCH) ? ST_FETCH2 : ST_DONE;
            end
            ST_FETCH2: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered ready/busy derived from the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ready_q  <= (state_next == ST_DONE);
            busy_q   <= (state_next != ST_IDLE);
        end
    end

    // Capture the request operands at acceptance. Later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_sel   <= bus.sel;
            op_addr  <= bus.addr[ADDR_W-1:0];
            op_wdata <= bus.wdata;
        end
    end

    // Memory access and the read-data and instruction result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the memory must come out of reset all-zero, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
            ir_q    <= '0;
        end else begin
            case (state)
                ST_ACCESS: begin
                    case (op_sel)
                        SEL_READ:  rdata_q        <= mem[op_addr];
                        SEL_WRITE: mem[op_addr]   <= op_wdata;
                        SEL_FETCH: ir_q[31:16]    <= mem[op_addr];
                        default:   ;
                    endcase
                end
                ST_FETCH2: begin
                    ir_q[15:0] <= mem[op_addr_inc];
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.ir_out = ir_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bus_mem_resp.sv
// Self-checking bench for bus_mem_resp. Two instances are used: one with two
// wait states for the main scenarios and one with zero wait states for the
// minimum-latency case. Expected results come from a reference memory model.
// They are queued at request time and compared when ready is observed.
module tb_bus_mem_resp;

    localparam int ADDR_W = 8;
    localparam int WS     = 2;
    localparam int BUDGET = 64;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] rdata;
        logic [31:0] ir;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t        sb_q[$];
    logic [15:0] model_mem [1 << ADDR_W];
    logic [15:0] model_rdata;
    logic [31:0] model_ir;

    bus_mem_resp_if bus ();
    bus_mem_resp_if bus0 ();

    bus_mem_resp #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bus_mem_resp #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            model_mem[i] = '0;
        end
        model_rdata = '0;
        model_ir    = '0;
        sb_q.delete();
    endtask

    // One full four-phase transaction on the two-wait-state instance.
    task automatic run_txn(input logic [1:0] sel, input logic [15:0] addr,
                           input logic [15:0] wdata, input int hold, input bit early);
        exp_t        e;
        exp_t        got;
        logic [7:0]  a;
        logic [7:0]  a1;
        int          edges;
        a  = addr[ADDR_W-1:0];
        a1 = a + 8'd1;
        bus.cs    = 1'b1;
        bus.sel   = sel;
        bus.addr  = addr;
        bus.wdata = wdata;
        case (sel)
            2'b01:   model_rdata = model_mem[a];
            2'b10:   model_mem[a] = wdata;
            2'b11:   model_ir = {model_mem[a], model_mem[a1]};
            default: ;
        endcase
        e.sel   = sel;
        e.rdata = model_rdata;
        e.ir    = model_ir;
        e.lat   = (sel == 2'b11) ? WS + 2 : WS + 1;
        sb_q.push_back(e);

        step();  // acceptance edge
        tests_run++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_status: busy=%b ready=%b, required busy=1 ready=0", bus.busy, bus.ready);
        end
        // Scramble the operands after acceptance; the DUT must use the latched copies.
        bus.sel   = ~sel;
        bus.addr  = ~addr;
        bus.wdata = ~wdata;
        if (early) bus.cs = 1'b0;

        edges = 0;
        while (bus.ready !== 1'b1 && edges < BUDGET) begin
            step();
            edges++;
        end
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_timeout: ready=%b after %0d edges, required 1", bus.ready, edges);
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            if (edges != got.lat || bus.rdata !== got.rdata || bus.ir_out !== got.ir
                || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL txn sel=%b addr=%h: lat=%0d rdata=%h ir=%h busy=%b, required lat=%0d rdata=%h ir=%h busy=1",
                         sel, addr, edges, bus.rdata, bus.ir_out, bus.busy, got.lat, got.rdata, got.ir);
            end
        end

        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                step();
                tests_run++;
                if (bus.ready !== 1'b1 || bus.busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL hold_cycle%0d: ready=%b busy=%b, required 1 1", i, bus.ready, bus.busy);
                end
            end
            bus.cs  = 1'b0;
            bus.sel = 2'b00;
        end
        step();
        tests_run++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL release: ready=%b busy=%b, required 0 0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.cs = 1'b0;  bus.sel = 2'b00;  bus.addr = '0;  bus.wdata = '0;
        bus0.cs = 1'b0; bus0.sel = 2'b00; bus0.addr = '0; bus0.wdata = '0;
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.rdata !== 16'h0 || bus.ir_out !== 32'h0 || bus.ready !== 1'b0 || bus.busy !== 1'b0
            || bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rdata=%h ir=%h ready=%b busy=%b ready0=%b busy0=%b, required all 0",
                     bus.rdata, bus.ir_out, bus.ready, bus.busy, bus0.ready, bus0.busy);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_write_read();
        run_txn(2'b10, 16'h0005, 16'hBEEF, 0, 1'b0);
        run_txn(2'b01, 16'h0005, 16'h0000, 0, 1'b0);
        tests_run++;
        if (bus.rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL write_read: rdata=%h, required BEEF", bus.rdata);
        end
    endtask

    task automatic test_fetch_wrap();
        run_txn(2'b10, 16'h00FF, 16'h1234, 0, 1'b0);
        run_txn(2'b10, 16'h0000, 16'hABCD, 0, 1'b0);
        run_txn(2'b11, 16'h00FF, 16'h0000, 0, 1'b0);
        tests_run++;
        if (bus.ir_out !== 32'h1234ABCD) begin
            tests_failed++;
            $display("FAIL fetch_wrap: ir_out=%h, required 1234ABCD", bus.ir_out);
        end
    endtask

    task automatic test_hold();
        run_txn(2'b01, 16'h00FF, 16'h0000, 5, 1'b0);
    endtask

    task automatic test_early_drop();
        run_txn(2'b10, 16'h0010, 16'h00AA, 0, 1'b0);
        run_txn(2'b01, 16'h0010, 16'h0000, 0, 1'b1);
        tests_run++;
        if (bus.rdata !== 16'h00AA) begin
            tests_failed++;
            $display("FAIL early_drop: rdata=%h, required 00AA", bus.rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        bus.cs = 1'b1; bus.sel = 2'b10; bus.addr = 16'h0020; bus.wdata = 16'h5555;
        step();   // accepted
        step();   // in WAIT
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.rdata !== 16'h0 || bus.ir_out !== 32'h0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_write: rdata=%h ir=%h ready=%b busy=%b, required all 0",
                     bus.rdata, bus.ir_out, bus.ready, bus.busy);
        end
        bus.cs = 1'b0; bus.sel = 2'b00;
        reset  = 1'b0;
        model_clear();
        step();
        run_txn(2'b01, 16'h0020, 16'h0000, 0, 1'b0);
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_write_lost: rdata=%h, required 0000", bus.rdata);
        end
    endtask

    task automatic test_w0_and_idle_sel();
        // Write then read on the zero-wait-state instance: ready one edge after acceptance.
        bus0.cs = 1'b1; bus0.sel = 2'b10; bus0.addr = 16'h0003; bus0.wdata = 16'h1357;
        step();
        bus0.wdata = 16'hFFFF;
        step();
        tests_run++;
        if (bus0.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL w0_write_latency: ready=%b, required 1", bus0.ready);
        end
        bus0.cs = 1'b0; bus0.sel = 2'b00;
        step();
        bus0.cs = 1'b1; bus0.sel = 2'b01; bus0.addr = 16'h0103;
        step();
        tests_run++;
        if (bus0.ready !== 1'b0 || bus0.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL w0_read_accept: ready=%b busy=%b, required 0 1", bus0.ready, bus0.busy);
        end
        step();
        tests_run++;
        if (bus0.ready !== 1'b1 || bus0.rdata !== 16'h1357) begin
            tests_failed++;
            $display("FAIL w0_read: ready=%b rdata=%h, required 1 1357", bus0.ready, bus0.rdata);
        end
        bus0.cs = 1'b0; bus0.sel = 2'b00;
        step();
        // cs with sel=00 is not a request.
        bus0.cs = 1'b1; bus0.sel = 2'b00;
        bus.cs  = 1'b1; bus.sel  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL sel_none%0d: ready0=%b busy0=%b ready=%b busy=%b, required all 0",
                         i, bus0.ready, bus0.busy, bus.ready, bus.busy);
            end
        end
        bus0.cs = 1'b0;
        bus.cs  = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  s;
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom_range(1, 3));
            a = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) a = {a[15:8], 8'hFF};
            d = 16'($urandom_range(0, 65535));
            run_txn(s, a, d, int'($urandom_range(0, 2)), (i % 4 == 1));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fetch_wrap();
        test_hold();
        test_early_drop();
        test_reset_mid_write();
        test_w0_and_idle_sel();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_mem_resp.md
Name: bus_mem_resp

Overview:
- Bus responder (memory side) for the BIU-initiated 16-bit transfer protocol.
- Accepts read, write and 32-bit instruction-fetch requests on the cs/sel handshake.
- Performs each request against an internal word memory after a programmable number of wait states.
- Returns read data and the fetched instruction, and drives the ready acknowledge back to the initiator.

Parameters:
ADDR_W, 8, word-address bits used; memory depth = 2^ADDR_W 16-bit words
WAIT_STATES, 2, idle cycles inserted between request acceptance and the memory access (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cs  input  1  request strobe from initiator; held high until ready seen
sel  input  2  operation: 00 none, 01 read, 10 write, 11 instruction fetch
addr  input  16  word address; only addr[ADDR_W-1:0] used
wdata  input  16  write data
rdata  output  16  read data, valid while ready=1 after a read
ir_out  output  32  fetched instruction {mem[a], mem[a+1]}, valid while ready=1 after a fetch
ready  output  1  transfer-complete acknowledge
busy  output  1  high from acceptance until return to IDLE

Behaviour:
- One clock (clk). reset is synchronous and active-high.
- Reset, sampled at a clk edge:
  - rdata=0, ir_out=0, ready=0, busy=0.
  - State=IDLE, wait counter=0, all memory words cleared to 0.
  - Reset mid-transaction aborts it. A write not yet in ACCESS is not committed.
- States: IDLE, WAIT, ACCESS, FETCH2, DONE.
- IDLE:
  - cs=1 and sel!=00 at edge N: latch sel, addr[ADDR_W-1:0] and wdata; busy=1.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - cs=1 with sel=00: ignored; stay IDLE, ready stays 0.
- WAIT:
  - Counter increments each cycle; after WAIT_STATES cycles in WAIT, go to ACCESS. Counter clears on exit.
- ACCESS (one cycle):
  - read: rdata<=mem[a]; go to DONE.
  - write: mem[a]<=wdata; go to DONE. rdata is unchanged.
  - fetch: ir_out[31:16]<=mem[a]; go to FETCH2.
- FETCH2: ir_out[15:0]<=mem[(a+1) mod 2^ADDR_W]; go to DONE. The address wraps at the memory top.
- DONE:
  - ready=1 (registered).
  - Stay in DONE while cs=1 (four-phase handshake).
  - When cs=0 is sampled, go to IDLE; ready=0 and busy=0 from the next cycle.
- Latency, request accepted at edge N (W=WAIT_STATES):
  - Read/write: ready=1 after edge N+W+1.
  - Fetch: ready=1 after edge N+W+2.
- Latched operands are used for the whole transaction. Changes to sel/addr/wdata after acceptance are ignored.
- Early cs drop: if cs falls during WAIT/ACCESS/FETCH2, the transaction still completes. ready is high for exactly one cycle in DONE, then the block returns to IDLE.
- No new request is accepted before returning to IDLE. A request presented in the same cycle DONE exits is not accepted. It must be held to the next IDLE cycle.
- rdata and ir_out hold their last values until overwritten by a later read or fetch.
- addr bits above ADDR_W are ignored, so addresses alias modulo 2^ADDR_W.

Test Plan:
- Write then read, W=2: cs=1 sel=10 addr=0x0005 wdata=0xBEEF; drop cs after ready. Then read sel=01 addr=0x0005 -> ready 3 edges after acceptance, rdata=0xBEEF.
- Fetch with wrap, ADDR_W=8: preload mem[0xFF]=0x1234, mem[0x00]=0xABCD; fetch addr=0x00FF -> ir_out=0x1234ABCD, ready 4 edges after acceptance.
- Hold handshake: keep cs=1 for 5 cycles after ready -> ready stays 1 and busy stays 1. Drop cs -> ready=0 one edge later, back in IDLE.
- Early cs drop: read addr=0x0010 (mem=0x00AA) with cs dropped one cycle after acceptance -> rdata=0x00AA, ready high exactly 1 cycle.
- Reset mid-write: write 0x5555 to addr 0x20, assert reset in WAIT -> outputs 0 next edge. A subsequent read of 0x20 returns 0x0000.
- W=0 and sel=00: with WAIT_STATES=0, read latency is 1 edge. cs=1 with sel=00 for 4 cycles -> ready and busy stay 0.
